// File: rtl/sprite_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Purpose  : Shared sprite types, default widths and address helper.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

   localparam int c_NUM_SPRITES = 8;
   localparam int c_ADDR_W      = 16;
   localparam int c_COLOR_W     = 9;
   localparam int c_DIM_W       = 6;
   localparam int c_ANIM_W      = 4;

   localparam logic [c_COLOR_W-1:0] c_TRANSPARENT = 9'h1FF;

   typedef struct packed {
      logic [c_ADDR_W-1:0] base;
      logic [c_DIM_W-1:0]  width;
      logic [c_DIM_W-1:0]  height;
      logic [c_ANIM_W-1:0] steps;
   } sprite_desc_t;

   // Callers truncate the result to their own address width.
   function automatic logic [31:0] sprite_addr(
      input logic [31:0] base,
      input logic [31:0] frame,
      input logic [31:0] width,
      input logic [31:0] height,
      input logic [31:0] x,
      input logic [31:0] y
   );
      return base + frame * width * height + y * width + x;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_unit_if
// Purpose  : Request/response handshake between a renderer and the fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_fetch_unit_if
   import sprite_pkg::*;
#(
   parameter int SEL_W   = $clog2(c_NUM_SPRITES),
   parameter int DIM_W   = c_DIM_W,
   parameter int COLOR_W = c_COLOR_W
) ();

   logic               req_valid;
   logic               req_ready;
   logic [SEL_W-1:0]   req_sel;
   logic [DIM_W-1:0]   req_x;
   logic [DIM_W-1:0]   req_y;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [COLOR_W-1:0] rsp_color;
   logic               rsp_hit;

   modport master (
      output req_valid, req_sel, req_x, req_y, rsp_ready,
      input  req_ready, rsp_valid, rsp_color, rsp_hit
   );

   modport slave (
      input  req_valid, req_sel, req_x, req_y, rsp_ready,
      output req_ready, rsp_valid, rsp_color, rsp_hit
   );

endinterface
`default_nettype wire

// File: rtl/sprite_desc_table.sv
`default_nettype none
// ============================================================================
// Module   : sprite_desc_table
// Purpose  : Sprite descriptor registers with per-slot animation counters.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_desc_table
   import sprite_pkg::*;
#(
   parameter  int NUM_SPRITES = c_NUM_SPRITES,
   parameter  int ADDR_W      = c_ADDR_W,
   parameter  int DIM_W       = c_DIM_W,
   parameter  int ANIM_W      = c_ANIM_W,
   localparam int SEL_W       = $clog2(NUM_SPRITES)
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              i_cfgWe,
   input  logic [SEL_W-1:0]  i_cfgSel,
   input  logic [ADDR_W-1:0] i_cfgBase,
   input  logic [DIM_W-1:0]  i_cfgWidth,
   input  logic [DIM_W-1:0]  i_cfgHeight,
   input  logic [ANIM_W-1:0] i_cfgSteps,
   input  logic              i_frameTick,
   input  logic [SEL_W-1:0]  i_rdSel,
   output logic [ADDR_W-1:0] o_rdBase,
   output logic [DIM_W-1:0]  o_rdWidth,
   output logic [DIM_W-1:0]  o_rdHeight,
   output logic [ANIM_W-1:0] o_rdFrame
);

   logic [ADDR_W-1:0] r_base   [NUM_SPRITES];
   logic [DIM_W-1:0]  r_width  [NUM_SPRITES];
   logic [DIM_W-1:0]  r_height [NUM_SPRITES];
   logic [ANIM_W-1:0] r_steps  [NUM_SPRITES];
   logic [ANIM_W-1:0] r_frame  [NUM_SPRITES];

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_base[i]   <= '0;
            r_width[i]  <= '0;
            r_height[i] <= '0;
            r_steps[i]  <= '0;
            r_frame[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            // A descriptor write restarts the animation and wins over a tick.
            if (i_cfgWe && (i_cfgSel == SEL_W'(i))) begin
               r_base[i]   <= i_cfgBase;
               r_width[i]  <= i_cfgWidth;
               r_height[i] <= i_cfgHeight;
               r_steps[i]  <= i_cfgSteps;
               r_frame[i]  <= '0;
            end else if (i_frameTick) begin
               if ((r_steps[i] <= ANIM_W'(1)) || (r_frame[i] >= r_steps[i] - ANIM_W'(1)))
                  r_frame[i] <= '0;
               else
                  r_frame[i] <= r_frame[i] + ANIM_W'(1);
            end
         end
      end
   end

   assign o_rdBase   = r_base[i_rdSel];
   assign o_rdWidth  = r_width[i_rdSel];
   assign o_rdHeight = r_height[i_rdSel];
   assign o_rdFrame  = r_frame[i_rdSel];

endmodule
`default_nettype wire

// File: rtl/sprite_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : sprite_fetch_unit
// Purpose  : Three-stage sprite pixel fetch pipeline with owned pixel memory.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_fetch_unit
   import sprite_pkg::*;
#(
   parameter  int                 NUM_SPRITES = c_NUM_SPRITES,
   parameter  int                 ADDR_W      = c_ADDR_W,
   parameter  int                 COLOR_W     = c_COLOR_W,
   parameter  int                 DIM_W       = c_DIM_W,
   parameter  int                 ANIM_W      = c_ANIM_W,
   parameter  logic [COLOR_W-1:0] TRANSPARENT = c_TRANSPARENT,
   localparam int                 SEL_W       = $clog2(NUM_SPRITES)
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               cfg_we,
   input  logic [SEL_W-1:0]   cfg_sel,
   input  logic [ADDR_W-1:0]  cfg_base,
   input  logic [DIM_W-1:0]   cfg_width,
   input  logic [DIM_W-1:0]   cfg_height,
   input  logic [ANIM_W-1:0]  cfg_steps,
   input  logic               pix_we,
   input  logic [ADDR_W-1:0]  pix_addr,
   input  logic [COLOR_W-1:0] pix_data,
   input  logic               frame_tick,
   sprite_fetch_unit_if.slave bus
);

   logic [ADDR_W-1:0] w_descBase;
   logic [DIM_W-1:0]  w_descWidth;
   logic [DIM_W-1:0]  w_descHeight;
   logic [ANIM_W-1:0] w_descFrame;
   logic              w_advance;

   logic              r_s1Valid;
   logic [ADDR_W-1:0] r_s1Base;
   logic [DIM_W-1:0]  r_s1Width;
   logic [DIM_W-1:0]  r_s1Height;
   logic [ANIM_W-1:0] r_s1Frame;
   logic [DIM_W-1:0]  r_s1X;
   logic [DIM_W-1:0]  r_s1Y;
   logic              r_s2Valid;
   logic              r_s2InBounds;
   logic [ADDR_W-1:0] r_s2Addr;
   logic              r_s3Valid;
   logic              r_s3InBounds;

   logic [COLOR_W-1:0] r_pixMem [2**ADDR_W];
   logic [COLOR_W-1:0] r_pixRead;

   sprite_desc_table #(
      .NUM_SPRITES (NUM_SPRITES),
      .ADDR_W      (ADDR_W),
      .DIM_W       (DIM_W),
      .ANIM_W      (ANIM_W)
   ) u_descTable (
      .Clock       (Clock),
      .Reset       (Reset),
      .i_cfgWe     (cfg_we),
      .i_cfgSel    (cfg_sel),
      .i_cfgBase   (cfg_base),
      .i_cfgWidth  (cfg_width),
      .i_cfgHeight (cfg_height),
      .i_cfgSteps  (cfg_steps),
      .i_frameTick (frame_tick),
      .i_rdSel     (bus.req_sel),
      .o_rdBase    (w_descBase),
      .o_rdWidth   (w_descWidth),
      .o_rdHeight  (w_descHeight),
      .o_rdFrame   (w_descFrame)
   );

   // An unconsumed response freezes every stage, so nothing can be overwritten.
   assign w_advance     = !(r_s3Valid && !bus.rsp_ready);
   assign bus.req_ready = w_advance;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_s1Valid    <= 1'b0;
         r_s1Base     <= '0;
         r_s1Width    <= '0;
         r_s1Height   <= '0;
         r_s1Frame    <= '0;
         r_s1X        <= '0;
         r_s1Y        <= '0;
         r_s2Valid    <= 1'b0;
         r_s2InBounds <= 1'b0;
         r_s2Addr     <= '0;
         r_s3Valid    <= 1'b0;
         r_s3InBounds <= 1'b0;
      end else if (w_advance) begin
         r_s1Valid    <= bus.req_valid;
         r_s1Base     <= w_descBase;
         r_s1Width    <= w_descWidth;
         r_s1Height   <= w_descHeight;
         r_s1Frame    <= w_descFrame;
         r_s1X        <= bus.req_x;
         r_s1Y        <= bus.req_y;
         r_s2Valid    <= r_s1Valid;
         // Zero width or height can never satisfy these, so disabled slots miss.
         r_s2InBounds <= (r_s1X < r_s1Width) && (r_s1Y < r_s1Height);
         r_s2Addr     <= ADDR_W'(sprite_addr(32'(r_s1Base), 32'(r_s1Frame), 32'(r_s1Width),
                                             32'(r_s1Height), 32'(r_s1X), 32'(r_s1Y)));
         r_s3Valid    <= r_s2Valid;
         r_s3InBounds <= r_s2InBounds;
      end
   end

   always_ff @(posedge Clock) begin
      if (pix_we)
         r_pixMem[pix_addr] <= pix_data;
      if (w_advance)
         r_pixRead <= r_pixMem[r_s2Addr];
   end

   assign bus.rsp_valid = r_s3Valid;
   assign bus.rsp_color = r_s3InBounds ? r_pixRead : TRANSPARENT;
   assign bus.rsp_hit   = r_s3InBounds && (r_pixRead != TRANSPARENT);

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_fetch_unit
// Purpose  : Scoreboard bench for sprite_fetch_unit against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_unit;
   import sprite_pkg::*;

   localparam logic [8:0] c_TRANSP = 9'h1FF;

   typedef struct {
      logic [8:0] color;
      logic       hit;
   } exp_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        cfgWe;
   logic [2:0]  cfgSel;
   logic [15:0] cfgBase;
   logic [5:0]  cfgWidth;
   logic [5:0]  cfgHeight;
   logic [3:0]  cfgSteps;
   logic        pixWe;
   logic [15:0] pixAddr;
   logic [8:0]  pixData;
   logic        frameTick;
   int          rdyMode;
   int          nCmp = 0;
   int          nBad = 0;

   sprite_desc_t mDesc  [8];
   int           mFrame [8];
   logic [8:0]   mMem   [0:65535];
   exp_t         q [$];

   sprite_fetch_unit_if bus ();

   sprite_fetch_unit dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .cfg_we     (cfgWe),
      .cfg_sel    (cfgSel),
      .cfg_base   (cfgBase),
      .cfg_width  (cfgWidth),
      .cfg_height (cfgHeight),
      .cfg_steps  (cfgSteps),
      .pix_we     (pixWe),
      .pix_addr   (pixAddr),
      .pix_data   (pixData),
      .frame_tick (frameTick),
      .bus        (bus)
   );

   always #5 Clock = ~Clock;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t refResp(int sel, int x, int y);
      exp_t r;
      int w = int'(mDesc[sel].width);
      int h = int'(mDesc[sel].height);
      int addr;
      if (w == 0 || h == 0 || x >= w || y >= h) begin
         r.color = c_TRANSP;
         r.hit   = 1'b0;
      end else begin
         addr    = (int'(mDesc[sel].base) + mFrame[sel] * w * h + y * w + x) % 65536;
         r.color = mMem[addr];
         r.hit   = (r.color != c_TRANSP);
      end
      return r;
   endfunction

   // Reference model and scoreboard, evaluated mid-cycle for the coming edge.
   always @(negedge Clock) begin
      exp_t e;
      int   n;
      if (Reset) begin
         q.delete();
         for (int i = 0; i < 8; i++) begin
            mDesc[i]  = '0;
            mFrame[i] = 0;
         end
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
               nCmp++;
               nBad++;
               $display("FAIL unexpectedRsp: got color %0h with no request outstanding", bus.rsp_color);
            end else begin
               e = q.pop_front();
               check("rspColor", 32'(bus.rsp_color), 32'(e.color));
               check("rspHit", 32'(bus.rsp_hit), 32'(e.hit));
            end
         end
         if (bus.rsp_valid && !bus.rsp_ready)
            check("stallReqReady", 32'(bus.req_ready), 0);
         if (bus.req_valid && bus.req_ready)
            q.push_back(refResp(int'(bus.req_sel), int'(bus.req_x), int'(bus.req_y)));
         if (pixWe)
            mMem[pixAddr] = pixData;
         if (frameTick)
            for (int i = 0; i < 8; i++) begin
               n = (mDesc[i].steps == 0) ? 1 : int'(mDesc[i].steps);
               mFrame[i] = (mFrame[i] + 1) % n;
            end
         if (cfgWe) begin
            mDesc[cfgSel]  = '{base: cfgBase, width: cfgWidth, height: cfgHeight, steps: cfgSteps};
            mFrame[cfgSel] = 0;
         end
      end
   end

   initial forever begin
      @(posedge Clock);
      #2;
      case (rdyMode)
         0:       bus.rsp_ready = 1'b1;
         1:       bus.rsp_ready = ($urandom % 3) != 0;
         default: bus.rsp_ready = 1'b0;
      endcase
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic writePix(int a, logic [8:0] d);
      pixWe = 1'b1; pixAddr = 16'(a); pixData = d;
      step();
      pixWe = 1'b0;
   endtask

   task automatic cfgWrite(int sel, int base, int w, int h, int s);
      cfgWe = 1'b1; cfgSel = 3'(sel); cfgBase = 16'(base);
      cfgWidth = 6'(w); cfgHeight = 6'(h); cfgSteps = 4'(s);
      step();
      cfgWe = 1'b0;
   endtask

   task automatic tick();
      frameTick = 1'b1;
      step();
      frameTick = 1'b0;
   endtask

   task automatic sendReq(int sel, int x, int y);
      int  n = 0;
      bit  acc;
      bus.req_valid = 1'b1; bus.req_sel = 3'(sel); bus.req_x = 6'(x); bus.req_y = 6'(y);
      do begin
         @(negedge Clock);
         acc = bus.req_ready;
         step();
         n++;
      end while (!acc && n < 100);
      if (!acc) begin
         nCmp++; nBad++;
         $display("FAIL reqAccept: got no acceptance in 100 cycles, required acceptance");
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge Clock);
         n++;
      end
      #1;
      check("drainQueue", q.size(), 0);
   endtask

   function automatic logic [8:0] randColor();
      return (($urandom % 5) == 0) ? c_TRANSP : 9'($urandom);
   endfunction

   initial begin
      int cnt;
      Reset = 1'b1; cfgWe = 1'b0; cfgSel = '0; cfgBase = '0; cfgWidth = '0; cfgHeight = '0;
      cfgSteps = '0; pixWe = 1'b0; pixAddr = '0; pixData = '0; frameTick = 1'b0; rdyMode = 0;
      bus.req_valid = 1'b0; bus.req_sel = '0; bus.req_x = '0; bus.req_y = '0; bus.rsp_ready = 1'b1;
      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      check("rstRspValid", 32'(bus.rsp_valid), 0);
      check("rstRspColor", 32'(bus.rsp_color), 32'(c_TRANSP));
      check("rstRspHit", 32'(bus.rsp_hit), 0);
      check("rstReqReady", 32'(bus.req_ready), 1);
      step();

      for (int a = 0; a < 2048; a++) writePix(a, randColor());
      for (int a = 16'hFFF0; a <= 16'hFFFF; a++) writePix(a, randColor());
      writePix(16'h014B, 9'h0A5);

      cfgWrite(2, 16'h0100, 8, 4, 3);
      tick();
      tick();
      sendReq(2, 3, 1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge Clock);
         check("latencyValid", 32'(bus.rsp_valid), 32'(c == 3));
         if (c == 3) begin
            check("frame2Color", 32'(bus.rsp_color), 32'h0A5);
            check("frame2Hit", 32'(bus.rsp_hit), 1);
         end
      end
      step();

      tick();
      sendReq(2, 3, 1);
      sendReq(2, 8, 0);
      sendReq(5, 0, 0);
      waitDrain();

      cfgWrite(6, 16'hFFF8, 4, 4, 2);
      tick();
      sendReq(6, 1, 2);
      sendReq(6, 3, 3);
      waitDrain();

      sendReq(2, 0, 0);
      sendReq(2, 7, 3);
      sendReq(6, 1, 1);
      fork
         begin
            rdyMode = 2;
            repeat (4) @(posedge Clock);
            rdyMode = 0;
         end
      join_none
      sendReq(2, 3, 2);
      sendReq(5, 1, 1);
      sendReq(6, 2, 3);
      waitDrain();

      cfgWe = 1'b1; cfgSel = 3'd2; cfgBase = 16'h0200; cfgWidth = 6'd4; cfgHeight = 6'd4; cfgSteps = 4'd2;
      sendReq(2, 1, 1);
      cfgWe = 1'b0;
      sendReq(2, 1, 1);
      frameTick = 1'b1;
      sendReq(6, 1, 1);
      frameTick = 1'b0;
      sendReq(6, 1, 1);
      waitDrain();

      for (int s = 0; s < 8; s++)
         cfgWrite(s, $urandom % 1024, $urandom % 8, $urandom % 8, $urandom % 5);
      rdyMode = 1;
      for (int i = 0; i < 400; i++) begin
         bus.req_valid = ($urandom % 3) != 0;
         bus.req_sel   = 3'($urandom % 8);
         bus.req_x     = 6'($urandom % 9);
         bus.req_y     = 6'($urandom % 9);
         frameTick     = ($urandom % 8) == 0;
         cfgWe         = ($urandom % 16) == 0;
         cfgSel        = 3'($urandom % 8);
         cfgBase       = 16'($urandom % 1024);
         cfgWidth      = 6'($urandom % 8);
         cfgHeight     = 6'($urandom % 8);
         cfgSteps      = 4'($urandom % 5);
         step();
      end
      bus.req_valid = 1'b0; frameTick = 1'b0; cfgWe = 1'b0; rdyMode = 0;
      waitDrain();

      sendReq(2, 0, 0);
      sendReq(2, 1, 0);
      sendReq(2, 2, 0);
      Reset = 1'b1;
      #1;
      check("rstDropValid", 32'(bus.rsp_valid), 0);
      step();
      step();
      Reset = 1'b0;
      cnt = 0;
      repeat (12) begin
         @(negedge Clock);
         if (bus.rsp_valid) cnt++;
      end
      check("postRstRsp", cnt, 0);
      waitDrain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
